// File: rtl/sr_latch_driver.sv
// Command-side controller for a clocked SR latch: accepts SET/RESET/TOGGLE/NOP
// over valid/ready, drives legal S/R/Enable pulses, then confirms Q/Qp readback.
module sr_latch_driver #(
  parameter int unsigned PULSE_CYCLES  = 2,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned TIMEOUT       = 8
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  output logic       S,
  output logic       R,
  output logic       Enable,
  input  logic       Q_fb,
  input  logic       Qp_fb,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] op_count
);

  localparam int unsigned COUNT_W  = 8;
  localparam int unsigned CNT_MAX0 = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_MAX  = (CNT_MAX0 > TIMEOUT) ? CNT_MAX0 : TIMEOUT;
  localparam int unsigned CNT_W    = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_RESET = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic                 target_q;
  logic                 target_d;
  logic                 s_d;
  logic                 r_d;
  logic                 en_d;
  logic                 busy_d;
  logic                 ready_d;
  logic                 done_d;
  logic                 error_d;
  logic [COUNT_W-1:0]   op_count_d;
  logic                 accept_c;
  logic                 match_c;

  // Handshake and readback qualification; Q==Qp can never equal (target, ~target).
  assign accept_c = cmd_valid && cmd_ready;
  assign match_c  = (Q_fb == target_q) && (Qp_fb == !target_q);

  // State register and registered outputs.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      target_q  <= 1'b0;
      S         <= 1'b0;
      R         <= 1'b0;
      Enable    <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
      op_count  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      target_q  <= target_d;
      S         <= s_d;
      R         <= r_d;
      Enable    <= en_d;
      busy      <= busy_d;
      cmd_ready <= ready_d;
      done      <= done_d;
      error     <= error_d;
      op_count  <= op_count_d;
    end
  end

  // Next-state logic and next values of every registered output.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    target_d   = target_q;
    done_d     = 1'b0;
    error_d    = error;
    op_count_d = op_count;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          error_d = 1'b0;
          if (cmd_op == OP_NOP) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DRIVE;
            cnt_d   = CNT_W'(PULSE_CYCLES - 1);
            if (cmd_op == OP_SET) begin
              target_d = 1'b1;
            end else if (cmd_op == OP_RESET) begin
              target_d = 1'b0;
            end else begin
              target_d = !Q_fb;
            end
          end
        end
      end
      ST_DRIVE: begin
        if (cnt_q == '0) begin
          state_d = ST_SETTLE;
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_CHECK;
          cnt_d   = CNT_W'(TIMEOUT);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_CHECK: begin
        if (match_c) begin
          state_d = ST_DONE;
        end else if (cnt_q == '0) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        done_d     = 1'b1;
        op_count_d = op_count + COUNT_W'(1);
        state_d    = ST_IDLE;
      end
      ST_ERR: begin
        error_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Drive outputs follow the state being entered so they align with it.
    en_d    = (state_d == ST_DRIVE);
    s_d     = en_d && target_d;
    r_d     = en_d && !target_d;
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
  end

  // S and R must never be driven together.
  assert property (@(posedge Clock) disable iff (!Reset_n) !(S && R));

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: latch model on the feedback path, a transaction-level
// timing model checked every cycle, plus directed scenarios with literal expectations.
module tb_sr_latch_driver;

  localparam int P  = 2;
  localparam int ST = 1;
  localparam int T  = 8;

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic       S, R, Enable;
  logic       Q_fb, Qp_fb;
  logic       busy, done, error;
  logic [7:0] op_count;

  // 0: real latch, 1: Q stuck 0 / Qp 1, 2: Q=Qp=1
  int   fb_mode = 0;
  logic lq = 1'b0;

  int errors = 0;
  int checks = 0;

  sr_latch_driver #(.PULSE_CYCLES(P), .SETTLE_CYCLES(ST), .TIMEOUT(T)) dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .S         (S),
    .R         (R),
    .Enable    (Enable),
    .Q_fb      (Q_fb),
    .Qp_fb     (Qp_fb),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .op_count  (op_count)
  );

  always #5 Clock = ~Clock;

  // Clocked SR latch: captures on the clock while Enable is high.
  always @(posedge Clock) begin
    if (Enable) begin
      if (S && !R) lq <= 1'b1;
      else if (R && !S) lq <= 1'b0;
    end
  end

  assign Q_fb  = (fb_mode == 0) ? lq  : (fb_mode == 2);
  assign Qp_fb = (fb_mode == 0) ? !lq : 1'b1;

  // Inputs as seen at each rising edge.
  logic       smp_valid = 1'b0;
  logic [1:0] smp_op = 2'b00;
  logic       smp_q = 1'b0;
  int         smp_mode = 0;
  always @(posedge Clock) begin
    smp_valid <= cmd_valid;
    smp_op    <= cmd_op;
    smp_q     <= Q_fb;
    smp_mode  <= fb_mode;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: each accepted command occupies a fixed window measured in
  // edges from its accept edge; outputs follow from the position in that window.
  bit         m_act = 0, m_wr = 0, m_tgt = 0, m_ok = 0, m_done = 0, m_err = 0;
  int         m_t = 0, m_end = 0;
  logic [7:0] m_cnt = 8'd0;
  bit         exp_en;

  initial begin
    forever begin
      @(negedge Clock);
      if (!Reset_n) begin
        m_act = 0; m_done = 0; m_err = 0; m_cnt = 8'd0; m_t = 0;
      end else begin
        m_done = 0;
        if (m_act) begin
          m_t++;
          if (m_t == m_end) begin
            m_act = 0;
            if (m_ok) begin m_done = 1; m_cnt = m_cnt + 8'd1; end
            else m_err = 1;
          end
        end else if (smp_valid) begin
          m_act = 1; m_t = 0; m_err = 0;
          m_wr  = (smp_op != 2'b00);
          m_tgt = (smp_op == 2'b01) ? 1'b1 : (smp_op == 2'b10) ? 1'b0 : !smp_q;
          m_ok  = !m_wr || (smp_mode == 0) || (smp_mode == 1 && !m_tgt);
          m_end = !m_wr ? 1 : (m_ok ? P + ST + 2 : P + ST + T + 2);
        end
      end
      exp_en = m_act && m_wr && (m_t < P);
      chk("enable", 32'(Enable), 32'(exp_en));
      chk("s", 32'(S), 32'(exp_en && m_tgt));
      chk("r", 32'(R), 32'(exp_en && !m_tgt));
      chk("s_r_exclusive", 32'(S && R), 32'(0));
      chk("busy", 32'(busy), 32'(m_act));
      chk("cmd_ready", 32'(cmd_ready), 32'(!m_act));
      chk("done", 32'(done), 32'(m_done));
      chk("error", 32'(error), 32'(m_err));
      chk("op_count", 32'(op_count), 32'(m_cnt));
    end
  end

  // Present op from a falling edge; returns at the falling edge after the accept edge.
  task automatic send(input logic [1:0] op);
    int  n = 0;
    bit  rdy;
    cmd_valid = 1'b1;
    cmd_op    = op;
    rdy = cmd_ready;
    while (!rdy && n < 64) begin
      @(negedge Clock);
      rdy = cmd_ready;
      n++;
    end
    if (!rdy) begin
      $display("FAIL accept_timeout: cmd_ready stayed 0 at %0t", $time);
      errors++;
      checks++;
    end
    @(posedge Clock);
    @(negedge Clock);
  endtask

  // Issue one command and record the first cycle (edges after accept) of done/error.
  task automatic run_op(input logic [1:0] op, output int done_at, output int err_at);
    done_at = 0;
    err_at  = 0;
    send(op);
    cmd_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge Clock);
      if (done && done_at == 0) done_at = k;
      if (error && err_at == 0) err_at = k;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    cmd_valid = 1'b0;
    while (!cmd_ready && n < 100) begin
      @(negedge Clock);
      n++;
    end
    chk("idle_reached", 32'(cmd_ready), 32'(1));
  endtask

  int d_at, e_at;

  initial begin
    // Reset state
    repeat (2) @(negedge Clock);
    chk("rst_ready", 32'(cmd_ready), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_count", 32'(op_count), 32'(0));
    chk("rst_drive", 32'({S, R, Enable}), 32'(0));
    #3 Reset_n = 1'b1;
    @(negedge Clock);

    // Single SET with a working latch
    run_op(2'b01, d_at, e_at);
    chk("set_done_latency", 32'(d_at), 32'(5));
    chk("set_count", 32'(op_count), 32'(1));
    chk("set_q", 32'(Q_fb), 32'(1));
    chk("set_err", 32'(e_at), 32'(0));

    // Back-to-back SET, RESET, TOGGLE, TOGGLE with valid held high
    send(2'b01);
    send(2'b10);
    chk("b2b_q_after_set", 32'(Q_fb), 32'(1));
    send(2'b11);
    chk("b2b_q_after_reset", 32'(Q_fb), 32'(0));
    send(2'b11);
    chk("b2b_q_after_toggle1", 32'(Q_fb), 32'(1));
    wait_idle();
    chk("b2b_q_after_toggle2", 32'(Q_fb), 32'(0));
    chk("b2b_count", 32'(op_count), 32'(5));

    // NOP with Q=1
    run_op(2'b01, d_at, e_at);
    run_op(2'b00, d_at, e_at);
    chk("nop_done_latency", 32'(d_at), 32'(1));
    chk("nop_q_held", 32'(Q_fb), 32'(1));
    chk("nop_count", 32'(op_count), 32'(7));

    // Q stuck at 0, then SET times out
    fb_mode = 1;
    run_op(2'b01, d_at, e_at);
    chk("stuck_no_done", 32'(d_at), 32'(0));
    chk("stuck_err_latency", 32'(e_at), 32'(13));
    chk("stuck_count", 32'(op_count), 32'(7));
    run_op(2'b00, d_at, e_at);
    chk("nop_clears_err", 32'(error), 32'(0));
    chk("nop_after_err_done", 32'(d_at), 32'(1));
    chk("nop_after_err_count", 32'(op_count), 32'(8));

    // Illegal Q=Qp=1 readback
    fb_mode = 2;
    run_op(2'b10, d_at, e_at);
    chk("illegal_no_done", 32'(d_at), 32'(0));
    chk("illegal_err_latency", 32'(e_at), 32'(13));
    chk("illegal_count", 32'(op_count), 32'(8));
    fb_mode = 0;
    @(negedge Clock);

    // Reset asserted in the middle of DRIVE
    send(2'b10);
    cmd_valid = 1'b0;
    @(posedge Clock);
    #1;
    chk("mid_drive_enable", 32'(Enable), 32'(1));
    #1 Reset_n = 1'b0;
    #1;
    chk("mid_rst_drive", 32'({S, R, Enable}), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_count", 32'(op_count), 32'(0));
    @(negedge Clock);
    #3 Reset_n = 1'b1;
    @(negedge Clock);
    chk("post_rst_ready", 32'(cmd_ready), 32'(1));
    run_op(2'b01, d_at, e_at);
    chk("post_rst_set_latency", 32'(d_at), 32'(5));
    chk("post_rst_count", 32'(op_count), 32'(1));

    // op_count wrap
    for (int i = 0; i < 254; i++) begin
      send(2'b00);
      wait_idle();
    end
    chk("count_255", 32'(op_count), 32'(255));
    run_op(2'b00, d_at, e_at);
    chk("count_wrap", 32'(op_count), 32'(0));
    chk("wrap_done", 32'(d_at), 32'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
